// File: rtl/icache_assoc.sv
// Instruction cache with multi-word lines, direct-mapped or 2-way LRU, refilled
// word by word over a stb/ack memory port, with a whole-cache flush.
module icache_assoc #(
    parameter int ADDR_W     = 15,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 32,
    parameter int WAYS       = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_stb,
    input  logic              i_ack,
    input  logic [31:0]       i_mem_data
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int SB = $clog2(SETS);
    localparam int TW = ADDR_W - 2 - WB - SB;

    typedef enum logic [1:0] {IDLE, REFILL, RESP, FLUSH} state_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [SB-1:0] set;
        logic [WB-1:0] word;
    } req_t;

    state_t state, state_n;
    req_t   req_q;
    logic   vic, vic_n;
    logic   flush_pend;
    logic [WB-1:0] wcnt;
    logic [SB-1:0] fcnt;
    logic [SETS-1:0] lru_q;

    logic hit_go, miss_go, fill_done, flush_clr, ack_ok, hit_way;
    logic [WAYS-1:0]       hit_w, inv_w;
    logic [WAYS-1:0][31:0] rd_w, rsp_w;

    logic [TW-1:0] cpu_tag;
    logic [SB-1:0] cpu_set;
    logic [WB-1:0] cpu_word;
    logic          unused_ok;

    assign cpu_word  = i_cpu_addr[2 +: WB];
    assign cpu_set   = i_cpu_addr[2+WB +: SB];
    assign cpu_tag   = i_cpu_addr[ADDR_W-1 -: TW];
    assign unused_ok = ^i_cpu_addr[1:0];

    assign o_stb      = (state == REFILL);
    assign o_stall    = (state == REFILL) || (state == FLUSH);
    assign o_mem_addr = {req_q.tag, req_q.set, wcnt, 2'b00};
    assign ack_ok     = o_stb && i_ack;

    // Per-way storage: tag/valid per set plus the line data words.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TW-1:0]   tag_q [SETS];
        logic [SETS-1:0] vld_q;
        logic [31:0]     dat_q [SETS*LINE_WORDS];

        always_ff @(posedge i_clk) begin
            if (ack_ok && vic == 1'(w))
                dat_q[{req_q.set, wcnt}] <= i_mem_data;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_q <= '0;
            end else if (flush_clr) begin
                vld_q[fcnt] <= 1'b0;
            end else if (miss_go && vic_n == 1'(w)) begin
                // victim goes invalid while it is being overwritten
                vld_q[cpu_set] <= 1'b0;
            end else if (fill_done && vic == 1'(w)) begin
                vld_q[req_q.set] <= 1'b1;
                tag_q[req_q.set] <= req_q.tag;
            end
        end

        assign hit_w[w] = vld_q[cpu_set] && (tag_q[cpu_set] == cpu_tag);
        assign inv_w[w] = !vld_q[cpu_set];
        assign rd_w[w]  = dat_q[{cpu_set, cpu_word}];
        assign rsp_w[w] = dat_q[{req_q.set, req_q.word}];
    end

    if (WAYS > 1) begin : g_lru
        // lru_q[set] names the way to evict next
        always_ff @(posedge i_clk) begin
            if (i_rst)          lru_q <= '0;
            else if (flush_clr) lru_q[fcnt] <= 1'b0;
            else if (hit_go)    lru_q[cpu_set] <= ~hit_way;
            else if (fill_done) lru_q[req_q.set] <= ~vic;
        end
        assign hit_way = hit_w[WAYS-1];
        assign vic_n   = inv_w[0] ? 1'b0 : (inv_w[WAYS-1] ? 1'b1 : lru_q[cpu_set]);
    end else begin : g_nolru
        assign lru_q   = '0;
        assign hit_way = 1'b0;
        assign vic_n   = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        hit_go    = 1'b0;
        miss_go   = 1'b0;
        fill_done = 1'b0;
        flush_clr = 1'b0;
        case (state)
            IDLE: begin
                if (i_flush) begin
                    state_n = FLUSH;
                end else if (i_req) begin
                    if (|hit_w) begin
                        hit_go = 1'b1;
                    end else begin
                        miss_go = 1'b1;
                        state_n = REFILL;
                    end
                end
            end
            REFILL: begin
                if (ack_ok && wcnt == '1) begin
                    fill_done = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP:    state_n = (flush_pend || i_flush) ? FLUSH : IDLE;
            FLUSH: begin
                flush_clr = 1'b1;
                if (fcnt == '1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q      <= '0;
            vic        <= 1'b0;
            wcnt       <= '0;
            fcnt       <= '0;
            flush_pend <= 1'b0;
            o_valid    <= 1'b0;
            o_instr    <= '0;
        end else begin
            o_valid <= 1'b0;
            if (miss_go) begin
                req_q.tag  <= cpu_tag;
                req_q.set  <= cpu_set;
                req_q.word <= cpu_word;
                vic        <= vic_n;
                wcnt       <= '0;
            end else if (ack_ok) begin
                wcnt <= wcnt + 1'b1;
            end
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
            if (state_n == FLUSH)
                flush_pend <= 1'b0;
            else if (i_flush && (state == REFILL || state == RESP))
                flush_pend <= 1'b1;
            if (hit_go) begin
                o_valid <= 1'b1;
                o_instr <= hit_way ? rd_w[WAYS-1] : rd_w[0];
            end else if (fill_done) begin
                // requested word may be the one arriving on this edge
                o_valid <= 1'b1;
                if (req_q.word == wcnt) o_instr <= i_mem_data;
                else                    o_instr <= vic ? rsp_w[WAYS-1] : rsp_w[0];
            end
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: expected words and memory addresses are
// queued at request time and retired as the cache responds.
module tb_icache_assoc;
    logic        clk = 1'b0;
    logic        rst, req, flush, ack;
    logic [14:0] cpu_addr;
    logic        valid, stall, stb;
    logic [31:0] instr, mem_data;
    logic [14:0] mem_addr;

    icache_assoc #(.ADDR_W(15), .LINE_WORDS(4), .SETS(32), .WAYS(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_cpu_addr(cpu_addr),
        .i_flush(flush), .o_valid(valid), .o_instr(instr), .o_stall(stall),
        .o_mem_addr(mem_addr), .o_stb(stb), .i_ack(ack), .i_mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ack_dly = 0, wait_cnt = 0;
    int extra_valid = 0, extra_stb = 0;
    logic [31:0] exp_rsp[$];
    logic [14:0] exp_addr[$];

    function automatic logic [31:0] mdata(input logic [14:0] a);
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // memory model: acks each strobe after ack_dly idle cycles
    initial begin
        ack = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (rst || !stb) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_dly) begin
                wait_cnt++;
                if (exp_addr.size() > 0) chk("addr_hold", 32'(mem_addr), 32'(exp_addr[0]));
            end else begin
                wait_cnt = 0;
                ack = 1'b1;
                mem_data = mdata(mem_addr);
                if (exp_addr.size() == 0) extra_stb++;
                else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
        end
    end

    // response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                if (exp_rsp.size() == 0) extra_valid++;
                else chk("instr", instr, exp_rsp.pop_front());
            end
        end
    end

    task automatic wait_valid(inout int cyc);
        do begin
            @(negedge clk);
            cyc++;
        end while (!valid && cyc < 300);
        if (cyc >= 300) begin
            chk("valid_timeout", 32'(cyc), 32'd0);
            exp_rsp.delete();
            exp_addr.delete();
        end
    endtask

    task automatic push_req(input logic [14:0] a, input bit hit);
        exp_rsp.push_back(mdata({a[14:2], 2'b00}));
        if (!hit)
            for (int k = 0; k < 4; k++) exp_addr.push_back({a[14:4], 4'h0} + 15'(4 * k));
        req = 1'b1;
        cpu_addr = a;
    endtask

    task automatic fetch(input logic [14:0] a, input bit hit);
        int cyc = 0;
        @(negedge clk);
        push_req(a, hit);
        wait_valid(cyc);
        req = 1'b0;
        chk(hit ? "hit_latency" : "miss_latency", 32'(cyc), hit ? 32'd1 : 32'(1 + 4 * (ack_dly + 1)));
        chk("words_left", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic count_stall(input string tag, input int exp);
        int n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        int cyc, g;
        rst = 1'b1; req = 1'b0; flush = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        fetch(15'h004, 1'b0);
        fetch(15'h00C, 1'b1);

        // LRU: re-touching 0x004 makes 0x204 the victim of 0x404
        fetch(15'h204, 1'b0);
        fetch(15'h004, 1'b1);
        fetch(15'h404, 1'b0);
        fetch(15'h004, 1'b1);
        fetch(15'h204, 1'b0);

        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        count_stall("flush_stall", 32);
        fetch(15'h004, 1'b0);

        // flush beats a simultaneous request to a resident line
        @(negedge clk);
        flush = 1'b1; req = 1'b1; cpu_addr = 15'h004;
        @(negedge clk);
        flush = 1'b0; req = 1'b0;
        chk("prio_valid", 32'(valid), 32'd0);
        chk("prio_stall", 32'(stall), 32'd1);
        count_stall("prio_stall_len", 32);
        fetch(15'h004, 1'b0);

        ack_dly = 3;
        fetch(15'h608, 1'b0);

        // reset after two acks of a refill
        @(negedge clk);
        push_req(15'h104, 1'b0);
        g = 0;
        while (exp_addr.size() > 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_mid_stb", 32'(stb), 32'd0);
        chk("rst_mid_acks", 32'(exp_addr.size()), 32'd2);
        rst = 1'b0;
        exp_addr.delete();
        exp_rsp.delete();
        fetch(15'h104, 1'b0);
        fetch(15'h108, 1'b1);

        // flush raised mid-refill is held until the response is delivered
        @(negedge clk);
        push_req(15'h304, 1'b0);
        g = 0;
        while (exp_addr.size() > 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cyc = 0;
        wait_valid(cyc);
        req = 1'b0;
        chk("pend_words_left", 32'(exp_addr.size()), 32'd0);
        chk("pend_rsp_stall", 32'(stall), 32'd0);
        @(negedge clk);
        count_stall("pend_flush_stall", 32);
        fetch(15'h304, 1'b0);
        fetch(15'h104, 1'b0);

        repeat (3) @(negedge clk);
        chk("extra_valid", 32'(extra_valid), 32'd0);
        chk("extra_stb", 32'(extra_stb), 32'd0);
        chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
